// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the multi-cycle restoring divider: data width and
// FSM state encodings.
package restoring_divider_pkg;

  // Highest bit index of an ALU data word; the divider width defaults to this + 1.
  localparam int DATA_INDEX_LIMIT = 31;

  // Divider control states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_FIN  = 2'b10
  } div_state_e;

endpackage : restoring_divider_pkg

// File: rtl/restoring_divider_subtractor.sv
// Ripple subtractor built from full-adder cells: computes A + ~B + 1.
// The borrow output is the inverted carry-out of the last cell.
module ripple_subtractor #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0]   carry;
  logic [N-1:0] b_inv;

  // Carry-in of 1 completes the two's-complement negation of B.
  assign carry[0] = 1'b1;
  assign b_inv    = ~b_i;

  // One full-adder cell per bit, chained through carry.
  for (genvar i = 0; i < N; i++) begin : g_cell
    logic p;
    assign p          = a_i[i] ^ b_inv[i];
    assign diff_o[i]  = p ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_inv[i]) | (carry[i] & p);
  end

  assign borrow_o = ~carry[N];

endmodule : ripple_subtractor

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Operands are latched on start, the result is presented with a one-cycle
// done pulse, and busy stays high while iterations run.
// CNT_W must satisfy 2**CNT_W > WIDTH.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DATA_INDEX_LIMIT + 1,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             busy_q, done_q, dbz_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] r_d, q_d;
  logic             last_iter;

  // The partial remainder shifted left with the next dividend bit; WIDTH+1
  // bits so a divisor with its MSB set never overflows the trial subtract.
  assign r_shift = {r_q, q_q[WIDTH-1]};

  ripple_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a_i     (r_shift),
    .b_i     ({1'b0, d_q}),
    .diff_o  (trial),
    .borrow_o(borrow)
  );

  // Next partial remainder and quotient for one restoring iteration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    r_d = r_shift[WIDTH-1:0];
    q_d = {q_q[WIDTH-2:0], ~borrow};
    if (!borrow) r_d = trial[WIDTH-1:0];
  end

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so all registers update together.
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE, DIV_FIN: begin
          done_q <= 1'b0;
          if (start_i) begin
            dbz_q <= 1'b0;
            if (divisor_i == '0) begin
              // Divide by zero skips the iterations entirely.
              state_q     <= DIV_FIN;
              quotient_q  <= '1;
              remainder_q <= dividend_i;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q <= DIV_RUN;
              r_q     <= '0;
              q_q     <= dividend_i;
              d_q     <= divisor_i;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= DIV_IDLE;
            busy_q  <= 1'b0;
          end
        end
        DIV_RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q     <= DIV_FIN;
            quotient_q  <= q_d;
            remainder_q <= r_d;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// Directed and randomised checks for the restoring divider.
// Cycle numbering: the clock edge that accepts start ends cycle 0, so the
// cycle after it is cycle 1. Outputs are sampled on the falling edge.
module tb_restoring_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, dbz;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt;
  int first_busy;
  logic overlap;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .busy_o       (busy),
    .done_o       (done),
    .div_by_zero_o(dbz)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands with start high across exactly one rising edge.
  task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d);
    start    = 1'b1;
    dividend = n;
    divisor  = d;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic start_div(input logic [W-1:0] n, input logic [W-1:0] d);
    @(negedge clk);
    busy_cnt   = 0;
    first_busy = -1;
    overlap    = 1'b0;
    issue(n, d);
  endtask

  // Wait for done starting at cycle cyc0; returns the cycle done was seen.
  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    forever begin
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (busy && done) overlap = 1'b1;
      if (done) break;
      if (cyc >= 200) begin
        check("done_timeout", 64'(done), 64'd1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  // Count done pulses over the next n cycles.
  task automatic count_dones(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  initial begin
    int cyc;
    int dones;
    logic [W-1:0] rn, rd;
    logic [63:0]  recon;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_q",    64'(quotient),  64'd0);
    check("rst_r",    64'(remainder), 64'd0);
    check("rst_busy", 64'(busy),      64'd0);
    check("rst_done", 64'(done),      64'd0);
    check("rst_dbz",  64'(dbz),       64'd0);
    rst_n = 1'b1;

    // 1. 100 / 7
    start_div(100, 7);
    wait_done(1, cyc);
    check("t1_cycle",      64'(cyc),        64'd33);
    check("t1_q",          64'(quotient),   64'd14);
    check("t1_r",          64'(remainder),  64'd2);
    check("t1_dbz",        64'(dbz),        64'd0);
    check("t1_busy_cnt",   64'(busy_cnt),   64'd32);
    check("t1_busy_first", 64'(first_busy), 64'd1);
    check("t1_overlap",    64'(overlap),    64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'(done),     64'd0);
    check("t1_q_held",     64'(quotient), 64'd14);

    // 2. MSB-set operands through the WIDTH+1 bit subtract.
    start_div(32'hFFFF_FFFF, 32'h8000_0000);
    wait_done(1, cyc);
    check("t2_q", 64'(quotient),  64'd1);
    check("t2_r", 64'(remainder), 64'h7FFF_FFFF);

    // 3. Divide by zero goes straight to the result state.
    start_div(5, 0);
    wait_done(1, cyc);
    check("t3_cycle", 64'(cyc),       64'd1);
    check("t3_q",     64'(quotient),  64'hFFFF_FFFF);
    check("t3_r",     64'(remainder), 64'd5);
    check("t3_dbz",   64'(dbz),       64'd1);
    @(negedge clk);
    check("t3_dbz_held", 64'(dbz),  64'd1);
    check("t3_done_low", 64'(done), 64'd0);
    start_div(9, 3);
    check("t3_dbz_clear", 64'(dbz), 64'd0);
    wait_done(1, cyc);
    check("t3b_q", 64'(quotient),  64'd3);
    check("t3b_r", 64'(remainder), 64'd0);

    // 4. Dividend below divisor, then back-to-back start in the done cycle.
    start_div(3, 10);
    wait_done(1, cyc);
    check("t4_q", 64'(quotient),  64'd0);
    check("t4_r", 64'(remainder), 64'd3);
    issue(81, 9);
    check("t4b_busy", 64'(busy), 64'd1);
    wait_done(1, cyc);
    check("t4b_cycle", 64'(cyc),       64'd33);
    check("t4b_q",     64'(quotient),  64'd9);
    check("t4b_r",     64'(remainder), 64'd0);

    // 5. Start during an active division is ignored.
    start_div(1000, 3);
    repeat (8) @(negedge clk);
    issue(7, 7);
    wait_done(10, cyc);
    check("t5_cycle", 64'(cyc),       64'd33);
    check("t5_q",     64'(quotient),  64'd333);
    check("t5_r",     64'(remainder), 64'd1);
    count_dones(40, dones);
    check("t5_single_done", 64'(dones), 64'd0);

    // 6. Asynchronous reset mid-division aborts it.
    start_div(1000, 3);
    repeat (13) @(negedge clk);
    check("t6_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_q",    64'(quotient),  64'd0);
    check("t6_r",    64'(remainder), 64'd0);
    check("t6_busy", 64'(busy),      64'd0);
    check("t6_done", 64'(done),      64'd0);
    check("t6_dbz",  64'(dbz),       64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, dones);
    check("t6_no_done", 64'(dones), 64'd0);
    start_div(12, 4);
    wait_done(1, cyc);
    check("t6b_q", 64'(quotient),  64'd3);
    check("t6b_r", 64'(remainder), 64'd0);

    // Randomised pairs against a reference model.
    for (int i = 0; i < 20; i++) begin
      rn = $urandom;
      rd = $urandom >> $urandom_range(0, 31);
      if (rd == '0) rd = 32'd1;
      start_div(rn, rd);
      wait_done(1, cyc);
      check($sformatf("rnd%0d_q", i), 64'(quotient),  64'(rn / rd));
      check($sformatf("rnd%0d_r", i), 64'(remainder), 64'(rn % rd));
      recon = 64'(quotient) * 64'(rd) + 64'(remainder);
      check($sformatf("rnd%0d_qdr", i), recon, 64'(rn));
      check($sformatf("rnd%0d_rltd", i), 64'(remainder < rd), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_restoring_divider
